// File: rtl/dcache_pkg.sv
// Shared widths, tag word layout and controller state encoding for the
// dcache tag SRAM controller.
package dcache_pkg;

    localparam int INDEX_WIDTH = 4;
    localparam int TAG_WIDTH   = 22;
    localparam int WORD_WIDTH  = TAG_WIDTH + 2;
    localparam int DEPTH       = 1 << INDEX_WIDTH;

    // Stored word layout: {valid, dirty, tag}
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_WIDTH-1:0] tag;
    } tag_word_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/dcache_tag_cmp.sv
// Tag compare on the word returned by the tag SRAM: hit, dirty and the stored
// (victim) tag.
module dcache_tag_cmp
    import dcache_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [TAG_WIDTH-1:0]  cmp_tag,
    output logic                  hit,
    output logic                  dirty,
    output logic [TAG_WIDTH-1:0]  tag
);

    tag_word_t stored;

    assign stored = tag_word_t'(word);
    assign hit    = stored.valid && (stored.tag == cmp_tag);
    assign dirty  = stored.valid && stored.dirty;
    assign tag    = stored.tag;

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Controller for the single-port dcache tag SRAM: runs the invalidate sweep
// after reset and on flush, issues lookups/updates, and reports the compare.
//
// Handshake: a request is accepted in a cycle where req_valid && req_ready.
// A read accepted in cycle N yields a one-cycle resp_valid pulse in N+1;
// writes produce no response.
module dcache_tag_ctrl
    import dcache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [INDEX_WIDTH-1:0] req_index,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    input  logic                   req_dirty,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic                   resp_dirty,
    output logic [TAG_WIDTH-1:0]   resp_tag,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [INDEX_WIDTH-1:0] sram_addr,
    output logic [WORD_WIDTH-1:0]  sram_din,
    input  logic [WORD_WIDTH-1:0]  sram_dout
);

    ctrl_state_t            state;
    ctrl_state_t            state_next;
    logic [INDEX_WIDTH-1:0] sweep_idx;
    logic                   flush_seen;   // current sweep owes a flush_done
    logic                   pending;      // read issued last cycle
    logic [TAG_WIDTH-1:0]   cmp_tag;
    logic                   accept;
    logic                   accept_rd;
    logic                   sweep_last;
    tag_word_t              wr_word;
    logic                   cmp_hit;
    logic                   cmp_dirty;
    logic [TAG_WIDTH-1:0]   cmp_stored;

    assign sweep_last = (sweep_idx == INDEX_WIDTH'(DEPTH - 1));
    // flush_req wins over a simultaneous request
    assign accept     = (state == IDLE) && !flush_req && req_valid;
    assign accept_rd  = accept && !req_write;

    assign wr_word.valid = 1'b1;
    assign wr_word.dirty = req_dirty;
    assign wr_word.tag   = req_tag;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_next;
    end

    // Next-state: sweep until the last index, one drain cycle, then idle
    always_comb begin
        state_next = state;
        unique case (state)
            INIT, FLUSH: if (sweep_last) state_next = DRAIN;
            DRAIN:       state_next = IDLE;
            IDLE:        if (flush_req) state_next = FLUSH;
            default:     state_next = INIT;
        endcase
    end

    // Sweep index, flush bookkeeping and the outstanding-lookup register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_idx  <= '0;
            flush_seen <= 1'b0;
            pending    <= 1'b0;
            cmp_tag    <= '0;
        end else begin
            pending <= accept_rd;
            if (accept_rd) cmp_tag <= req_tag;
            unique case (state)
                INIT: begin
                    sweep_idx <= sweep_idx + INDEX_WIDTH'(1);
                    if (flush_req) flush_seen <= 1'b1;
                end
                FLUSH: sweep_idx <= sweep_idx + INDEX_WIDTH'(1);
                DRAIN: flush_seen <= 1'b0;
                IDLE: begin
                    if (flush_req) begin
                        sweep_idx  <= '0;
                        flush_seen <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: SRAM port drive, ready and flush completion
    always_comb begin
        req_ready  = 1'b0;
        flush_done = 1'b0;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_addr  = '0;
        sram_din   = '0;
        unique case (state)
            INIT, FLUSH: begin
                // state is INIT while rst_n is low; keep the macro deselected then
                sram_csb  = ~rst_n;
                sram_web  = ~rst_n;
                sram_addr = sweep_idx;
            end
            DRAIN: flush_done = flush_seen;
            IDLE: begin
                req_ready = ~flush_req;
                if (accept) begin
                    sram_csb  = 1'b0;
                    sram_web  = ~req_write;
                    sram_addr = req_index;
                    if (req_write) sram_din = WORD_WIDTH'(wr_word);
                end
            end
            default: ;
        endcase
    end

    dcache_tag_cmp u_cmp (
        .word    (sram_dout),
        .cmp_tag (cmp_tag),
        .hit     (cmp_hit),
        .dirty   (cmp_dirty),
        .tag     (cmp_stored)
    );

    assign resp_valid = pending;
    assign resp_hit   = pending & cmp_hit;
    assign resp_dirty = pending & cmp_dirty;
    assign resp_tag   = pending ? cmp_stored : '0;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl with a behavioural tag SRAM behind it.
module tb_dcache_tag_ctrl;

    localparam int IW    = dcache_pkg::INDEX_WIDTH;
    localparam int TW    = dcache_pkg::TAG_WIDTH;
    localparam int WW    = dcache_pkg::WORD_WIDTH;
    localparam int DEPTH = dcache_pkg::DEPTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [IW-1:0] req_index = '0;
    logic [TW-1:0] req_tag = '0;
    logic          req_dirty = 1'b0;
    logic          resp_valid;
    logic          resp_hit;
    logic          resp_dirty;
    logic [TW-1:0] resp_tag;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          sram_csb;
    logic          sram_web;
    logic [IW-1:0] sram_addr;
    logic [WW-1:0] sram_din;
    logic [WW-1:0] sram_dout;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    dcache_tag_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .req_dirty  (req_dirty),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_dirty (resp_dirty),
        .resp_tag   (resp_tag),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    // behavioural tag SRAM macro: registers on csb=0, commits writes one edge later
    logic [WW-1:0] mem [DEPTH];
    logic          r_web = 1'b1;
    logic [IW-1:0] r_addr = '0;
    logic [WW-1:0] r_din = '0;

    always @(posedge clk) begin
        if (!r_web) mem[r_addr] <= r_din;
        if (!sram_csb) begin
            r_web  <= sram_web;
            r_addr <= sram_addr;
            r_din  <= sram_din;
        end
    end
    assign sram_dout = mem[r_addr];

    // scoreboard counters
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: cache contents by index, expected responses in order
    logic          m_valid [DEPTH];
    logic          m_dirty [DEPTH];
    logic [TW-1:0] m_tag   [DEPTH];
    logic [TW+1:0] exp_q[$];
    logic [TW+1:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
            end
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_resp_valid", 32'(resp_valid), 32'(1'b1));
                check("mon_resp_hit",   32'(resp_hit),   32'(e[TW+1]));
                check("mon_resp_dirty", 32'(resp_dirty), 32'(e[TW]));
                check("mon_resp_tag",   32'(resp_tag),   32'(e[TW-1:0]));
            end else begin
                check("mon_resp_idle", 32'(resp_valid), 32'(1'b0));
            end
            if (flush_done) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
                end
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    m_valid[req_index] = 1'b1;
                    m_dirty[req_index] = req_dirty;
                    m_tag[req_index]   = req_tag;
                end else begin
                    exp_q.push_back({m_valid[req_index] && (m_tag[req_index] == req_tag),
                                     m_valid[req_index] && m_dirty[req_index],
                                     m_tag[req_index]});
                end
            end
        end
    end

    // driver tasks
    task automatic drive(input logic v, input logic w, input logic [IW-1:0] i,
                         input logic [TW-1:0] t, input logic d);
        req_valid = v; req_write = w; req_index = i; req_tag = t; req_dirty = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // expects the sweep starting in the current cycle; ends at negedge of cycle 17
    task automatic check_init_seq();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("init_csb",   32'(sram_csb),   32'(1'b0));
            check("init_web",   32'(sram_web),   32'(1'b0));
            check("init_addr",  32'(sram_addr),  32'(i));
            check("init_din",   32'(sram_din),   32'(0));
            check("init_ready", 32'(req_ready),  32'(1'b0));
            check("init_fdone", 32'(flush_done), 32'(1'b0));
            next_cycle();
        end
        @(negedge clk);
        check("drain_csb",   32'(sram_csb),   32'(1'b1));
        check("drain_ready", 32'(req_ready),  32'(1'b0));
        check("drain_fdone", 32'(flush_done), 32'(1'b0));
        next_cycle();
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'(1'b1));
    endtask

    task automatic check_resp(input string name, input logic h, input logic d, input logic [TW-1:0] t);
        check({name, "_valid"}, 32'(resp_valid), 32'(1'b1));
        check({name, "_hit"},   32'(resp_hit),   32'(h));
        check({name, "_dirty"}, 32'(resp_dirty), 32'(d));
        check({name, "_tag"},   32'(resp_tag),   32'(t));
    endtask

    function automatic logic [TW-1:0] rnd_tag();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return TW'(22'h000001);
            2:       return TW'(22'h3FFFFF);
            default: return TW'(22'h155555);
        endcase
    endfunction

    typedef struct {
        logic          wr;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic          dirty;
        logic          e_hit;
        logic          e_dirty;
        logic [TW-1:0] e_tag;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int got;
        int first_k;
        int second_k;

        vecs[0] = '{1'b1, 4'd5,  22'h012345, 1'b1, 1'b0, 1'b0, 22'h0};
        vecs[1] = '{1'b0, 4'd5,  22'h012345, 1'b0, 1'b1, 1'b1, 22'h012345};
        vecs[2] = '{1'b0, 4'd5,  22'h000001, 1'b0, 1'b0, 1'b1, 22'h012345};
        vecs[3] = '{1'b1, 4'd0,  22'h3FFFFF, 1'b0, 1'b0, 1'b0, 22'h0};
        vecs[4] = '{1'b0, 4'd0,  22'h3FFFFF, 1'b0, 1'b1, 1'b0, 22'h3FFFFF};
        vecs[5] = '{1'b0, 4'd15, 22'h000000, 1'b0, 1'b0, 1'b0, 22'h0};
        vecs[6] = '{1'b1, 4'd15, 22'h000000, 1'b1, 1'b0, 1'b0, 22'h0};
        vecs[7] = '{1'b0, 4'd15, 22'h000000, 1'b0, 1'b1, 1'b1, 22'h0};
        vecs[8] = '{1'b1, 4'd5,  22'h2AAAAA, 1'b0, 1'b0, 1'b0, 22'h0};
        vecs[9] = '{1'b0, 4'd5,  22'h2AAAAA, 1'b0, 1'b1, 1'b0, 22'h2AAAAA};

        // reset values, then the power-up sweep
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready),  32'(1'b0));
        check("rst_rvalid", 32'(resp_valid), 32'(1'b0));
        check("rst_hit",   32'(resp_hit),   32'(1'b0));
        check("rst_dirty", 32'(resp_dirty), 32'(1'b0));
        check("rst_tag",   32'(resp_tag),   32'(0));
        check("rst_fdone", 32'(flush_done), 32'(1'b0));
        check("rst_csb",   32'(sram_csb),   32'(1'b1));
        check("rst_web",   32'(sram_web),   32'(1'b1));
        check("rst_addr",  32'(sram_addr),  32'(0));
        check("rst_din",   32'(sram_din),   32'(0));
        rst_n = 1'b1;
        check_init_seq();
        next_cycle();

        // back-to-back reads of idx 0..3 right after init: all misses
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1'b1, 1'b0, IW'(i), TW'(i + 1), 1'b0);
            else       drive(1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            if (i > 0) check_resp("b2b", 1'b0, 1'b0, '0);
            next_cycle();
        end

        // table-driven vectors, one request then one idle cycle each
        foreach (vecs[v]) begin
            drive(1'b1, vecs[v].wr, vecs[v].idx, vecs[v].tag, vecs[v].dirty);
            @(negedge clk);
            check("vec_ready", 32'(req_ready), 32'(1'b1));
            next_cycle();
            drive(1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            if (vecs[v].wr) check("vec_wr_noresp", 32'(resp_valid), 32'(1'b0));
            else            check_resp("vec", vecs[v].e_hit, vecs[v].e_dirty, vecs[v].e_tag);
            next_cycle();
        end

        // write then read of the same index in consecutive cycles
        drive(1'b1, 1'b1, IW'(9), TW'(22'h000777), 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, IW'(9), TW'(22'h000777), 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check_resp("raw", 1'b1, 1'b1, TW'(22'h000777));
        next_cycle();

        // read, then flush together with a request: request refused, pending response delivered
        drive(1'b1, 1'b0, IW'(0), TW'(22'h3FFFFF), 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, IW'(5), TW'(22'h2AAAAA), 1'b0);
        flush_req = 1'b1;
        @(negedge clk);
        check_resp("flush_pending", 1'b1, 1'b0, TW'(22'h3FFFFF));
        check("flush_ready", 32'(req_ready), 32'(1'b0));
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        flush_req = 1'b0;
        got = 0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            @(negedge clk);
            if (flush_done) begin
                got = 1;
                check("flush_latency", 32'(k), 32'(17));
            end else if (k <= DEPTH) begin
                check("flush_csb",  32'(sram_csb),  32'(1'b0));
                check("flush_addr", 32'(sram_addr), 32'(k - 1));
            end
            next_cycle();
        end
        if (got == 0) check("flush_done_timeout", 32'(0), 32'(1));
        drive(1'b1, 1'b0, IW'(5), TW'(22'h2AAAAA), 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check_resp("post_flush", 1'b0, 1'b0, '0);
        next_cycle();

        // flush_req held high: a second sweep follows the first
        flush_req = 1'b1;
        first_k = -1;
        second_k = -1;
        for (int k = 0; k < 60 && second_k < 0; k++) begin
            @(negedge clk);
            if (flush_done) begin
                if (first_k < 0) first_k = k;
                else begin
                    second_k = k;
                    flush_req = 1'b0;
                end
            end
            next_cycle();
        end
        flush_req = 1'b0;
        check("hold_first",  32'(first_k),  32'(17));
        check("hold_second", 32'(second_k), 32'(35));
        @(negedge clk);
        next_cycle();

        // randomized traffic with occasional flush pulses, checked by the model
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  IW'($urandom_range(0, DEPTH - 1)), rnd_tag(), 1'($urandom_range(0, 1)));
            flush_req = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            next_cycle();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        flush_req = 1'b0;
        repeat (40) next_cycle();

        // reset in the middle of a flush sweep at index 7
        flush_req = 1'b1;
        next_cycle();
        flush_req = 1'b0;
        got = 0;
        for (int k = 0; k < 30 && got == 0; k++) begin
            @(negedge clk);
            if (!sram_csb && !sram_web && sram_addr == IW'(7)) got = 1;
            else next_cycle();
        end
        check("midflush_reached", 32'(got), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_ready",  32'(req_ready),  32'(1'b0));
        check("mrst_rvalid", 32'(resp_valid), 32'(1'b0));
        check("mrst_fdone",  32'(flush_done), 32'(1'b0));
        check("mrst_csb",    32'(sram_csb),   32'(1'b1));
        check("mrst_web",    32'(sram_web),   32'(1'b1));
        check("mrst_addr",   32'(sram_addr),  32'(0));
        check("mrst_din",    32'(sram_din),   32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_init_seq();
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
